fetch_pc_unit: RTL and testbench

- Datapath companion directly downstream of the multicycle control FSM.
- Consumes the FSM's pc_en, pc_mux, j_en, ir_en and flags_en strobes.
- Holds the program counter, instruction register and processor status flags.
- Feeds opcode and flags back to the FSM and drives the instruction fetch address to memory port A.

---
 rtl/fetch_pc_unit.sv | 90 +++++++++
 tb/tb_fetch_pc_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch datapath: program counter, instruction register and status flags driven by the control FSM strobes.
// Optional instret/taken_cnt performance counters are enabled with `define FETCH_PERF_COUNTERS_EN.
module fetch_pc_unit #(
  parameter int unsigned             ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0,
  parameter int unsigned             DISP_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              pc_mux,
  input  logic              j_en,
  input  logic              ir_en,
  input  logic              flags_en,
  input  logic [15:0]       mem_rdata,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [4:0]        alu_flags,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic [15:0]       opcode,
  output logic [4:0]        flags,
  output logic              ir_valid,
  output logic              halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]       instret,
  output logic [31:0]       taken_cnt
`endif
);

  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_update;

  // Displacement comes from the opcode held before this edge, relative to the branch's own pc.
  assign disp_ext  = {{(ADDR_W-DISP_W){opcode[DISP_W-1]}}, opcode[DISP_W-1:0]};
  assign pc_update = j_en | pc_en;
  assign link_addr = pc + ADDR_W'(1);

  always_comb begin
    pc_next = pc;
    if (j_en) begin
      pc_next = jump_target;
    end else if (pc_en && pc_mux) begin
      pc_next = pc + disp_ext;
    end else if (pc_en) begin
      pc_next = pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      opcode   <= 16'h0000;
      flags    <= 5'b00000;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      pc <= pc_next;
      if (ir_en) begin
        opcode   <= mem_rdata;
        ir_valid <= 1'b1;
      end
      if (flags_en) begin
        flags <= alu_flags;
      end
      // A self-targeting update means the program parked itself; flag it but keep executing.
      if (pc_update && (pc_next == pc)) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      instret   <= 32'd0;
      taken_cnt <= 32'd0;
    end else begin
      if (pc_update) begin
        instret <= instret + 32'd1;
      end
      if (j_en || (pc_en && pc_mux)) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: hand-computed PC/IR/flags expectations, including wrap and halt cases.
module tb_fetch_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_en, pc_mux, j_en, ir_en, flags_en;
  logic [15:0] mem_rdata;
  logic [15:0] jump_target;
  logic [4:0]  alu_flags;
  logic [15:0] pc, link_addr, opcode;
  logic [4:0]  flags;
  logic        ir_valid, halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] instret, taken_cnt;
  logic [31:0] exp_instret, exp_taken;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fetch_pc_unit #(
    .ADDR_W   (16),
    .RESET_PC (16'h0010),
    .DISP_W   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_en       (pc_en),
    .pc_mux      (pc_mux),
    .j_en        (j_en),
    .ir_en       (ir_en),
    .flags_en    (flags_en),
    .mem_rdata   (mem_rdata),
    .jump_target (jump_target),
    .alu_flags   (alu_flags),
    .pc          (pc),
    .link_addr   (link_addr),
    .opcode      (opcode),
    .flags       (flags),
    .ir_valid    (ir_valid),
    .halted      (halted)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .instret     (instret),
    .taken_cnt   (taken_cnt)
`endif
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes, then sample 1 time unit after the rising edge.
  task automatic apply(input logic rst, input logic pe, input logic pm, input logic je,
                       input logic ie, input logic fe, input logic [15:0] rd,
                       input logic [15:0] jt, input logic [4:0] af);
    reset = rst; pc_en = pe; pc_mux = pm; j_en = je; ir_en = ie; flags_en = fe;
    mem_rdata = rd; jump_target = jt; alu_flags = af;
`ifdef FETCH_PERF_COUNTERS_EN
    if (rst) begin
      exp_instret = 32'd0;
      exp_taken   = 32'd0;
    end else begin
      if (pe || je) exp_instret = exp_instret + 32'd1;
      if (je || (pe && pm)) exp_taken = exp_taken + 32'd1;
    end
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000);
  endtask

  initial begin
    // Reset with every strobe high: reset must win
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hABCD, 5'b11111);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hABCD, 5'b11111);
    check_val("rst_pc",       32'(pc),        32'h0010);
    check_val("rst_opcode",   32'(opcode),    32'h0000);
    check_val("rst_flags",    32'(flags),     32'h00);
    check_val("rst_ir_valid", 32'(ir_valid),  32'h0);
    check_val("rst_halted",   32'(halted),    32'h0);
    check_val("rst_link",     32'(link_addr), 32'h0011);

    // Jump to 0020, capture C5FE, then branch by -2
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0020, 5'b00000);
    check_val("jmp_pc",  32'(pc),     32'h0020);
    check_val("jmp_hlt", 32'(halted), 32'h0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hC5FE, 16'h0000, 5'b00000);
    check_val("ir_opcode", 32'(opcode),   32'hC5FE);
    check_val("ir_valid",  32'(ir_valid), 32'h1);
    check_val("ir_pc",     32'(pc),       32'h0020);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000);
    check_val("br_neg2_pc", 32'(pc), 32'h001E);
    idle();
    check_val("hold_pc", 32'(pc), 32'h001E);

    // Branch and IR capture in the same cycle: displacement uses old opcode C5FE
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h0000, 5'b00000);
    check_val("same_cyc_pc",     32'(pc),     32'h001C);
    check_val("same_cyc_opcode", 32'(opcode), 32'h1111);

    // Increment wrap from FFFF
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 5'b00000);
    check_val("link_wrap", 32'(link_addr), 32'h0000);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000);
    check_val("inc_wrap_pc", 32'(pc),        32'h0000);
    check_val("inc_link",    32'(link_addr), 32'h0001);

    // Negative branch below zero: 0003 + (-8) = FFFB
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00F8, 16'h0003, 5'b00000);
    check_val("ld_f8_pc",     32'(pc),     32'h0003);
    check_val("ld_f8_opcode", 32'(opcode), 32'h00F8);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000);
    check_val("br_wrap_pc", 32'(pc), 32'hFFFB);

    // Flags capture and hold
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 5'b10010);
    check_val("flags_load", 32'(flags), 32'h12);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b01101);
    check_val("flags_hold", 32'(flags), 32'h12);

    // Jump beats branch and increment; flags untouched without flags_en
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 5'b11111);
    check_val("jprio_pc",    32'(pc),    32'h1234);
    check_val("jprio_flags", 32'(flags), 32'h12);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000);
    check_val("inc_pc",   32'(pc),        32'h1235);
    check_val("inc_link2", 32'(link_addr), 32'h1236);

    // Self-loop branch sets halted; later updates still proceed
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hCE00, 16'h0040, 5'b00000);
    check_val("pre_halt_pc",  32'(pc),     32'h0040);
    check_val("pre_halt_hlt", 32'(halted), 32'h0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000);
    check_val("halt_pc",  32'(pc),     32'h0040);
    check_val("halt_hlt", 32'(halted), 32'h1);
`ifdef FETCH_PERF_COUNTERS_EN
    check_val("halt_instret", instret,   exp_instret);
    check_val("halt_taken",   taken_cnt, exp_taken);
`endif
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000);
    check_val("post_halt_pc",  32'(pc),     32'h0041);
    check_val("post_halt_hlt", 32'(halted), 32'h1);
    idle();
    check_val("sticky_hlt", 32'(halted), 32'h1);
`ifdef FETCH_PERF_COUNTERS_EN
    check_val("post_instret", instret,   exp_instret);
    check_val("post_taken",   taken_cnt, exp_taken);
`endif

    // Reset clears halted and ir_valid
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000);
    check_val("rst2_hlt",  32'(halted),   32'h0);
    check_val("rst2_irv",  32'(ir_valid), 32'h0);
    check_val("rst2_pc",   32'(pc),       32'h0010);
    check_val("rst2_flag", 32'(flags),    32'h00);
`ifdef FETCH_PERF_COUNTERS_EN
    check_val("rst2_instret", instret,   32'd0);
    check_val("rst2_taken",   taken_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
